// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU share arbiter: opcode encoding, request bundle,
// output-register state and a one-hot helper.
package alu_share_arbiter_pkg;

    localparam int NumAluReq = 2;
    localparam int AluXlen   = 32;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSlt  = 4'd5,
        AluSltu = 4'd6,
        AluSll  = 4'd7,
        AluSrl  = 4'd8,
        AluSra  = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [3:0]         op;
        logic [AluXlen-1:0] a;
        logic [AluXlen-1:0] b;
    } alu_req_t;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } arb_state_e;

    function automatic logic [NumAluReq-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic; the last winner loses the next contention.
// Reusable for any shared unit with a valid/advance handshake.
module rr_arbiter2
    import alu_share_arbiter_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NumAluReq-1:0] i_valid,
    input  logic                 i_advance,
    output logic [NumAluReq-1:0] o_grant
);

    logic r_last_grant;

    // Pick a single winner among the valid requesters.
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = req_onehot(!r_last_grant);
            default: o_grant = 2'b00;
        endcase
    end

    // Remember the winner only when its request was actually taken.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
        end else if (i_advance) begin
            r_last_grant <= o_grant[1];
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with a single-entry
// result register. Optional statistics counters under ALU_ARB_STATS_EN.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [1:0]      i_req_valid,
    output logic [1:0]      o_req_ready,
    input  logic [3:0]      i_req0_op,
    input  logic [XLEN-1:0] i_req0_a,
    input  logic [XLEN-1:0] i_req0_b,
    input  logic [3:0]      i_req1_op,
    input  logic [XLEN-1:0] i_req1_a,
    input  logic [XLEN-1:0] i_req1_b,
    output logic [1:0]      o_rsp_valid,
    input  logic [1:0]      i_rsp_ready,
    output logic [XLEN-1:0] o_rsp_data,
    output logic            o_rsp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]     o_grant_cnt0,
    output logic [31:0]     o_grant_cnt1,
    output logic [31:0]     o_conflict_cnt
`endif
);

    localparam int ShW = $clog2(XLEN);

    arb_state_e      r_state;
    logic            r_owner;
    logic [1:0]      r_rsp_valid;
    logic [XLEN-1:0] r_rsp_data;
    logic            r_rsp_zero;

    logic [1:0]      w_grant;
    logic            w_drain;
    logic            w_can_accept;
    logic            w_accept;
    logic            w_gnt_idx;
    logic [3:0]      w_op;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_alu_result;

    assign w_drain      = (r_state == StFull) && i_rsp_ready[r_owner];
    assign w_can_accept = (r_state == StEmpty) || w_drain;
    assign w_accept     = w_can_accept && (|w_grant);
    assign w_gnt_idx    = w_grant[1];

    rr_arbiter2 u_rr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_req_valid),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    // Ready goes only to the granted requester, and only when the register frees up.
    always_comb begin
        o_req_ready = 2'b00;
        if (w_can_accept) begin
            o_req_ready = w_grant;
        end else begin
            o_req_ready = 2'b00;
        end
    end

    assign w_op = w_gnt_idx ? i_req1_op : i_req0_op;
    assign w_a  = w_gnt_idx ? i_req1_a  : i_req0_a;
    assign w_b  = w_gnt_idx ? i_req1_b  : i_req0_b;

    // Shared ALU, register-register form (operand B is rs2, no immediate).
    always_comb begin
        w_alu_result = {XLEN{1'b0}};
        case (alu_op_e'(w_op))
            AluAdd:  w_alu_result = w_a + w_b;
            AluSub:  w_alu_result = w_a - w_b;
            AluAnd:  w_alu_result = w_a & w_b;
            AluOr:   w_alu_result = w_a | w_b;
            AluXor:  w_alu_result = w_a ^ w_b;
            AluSlt:  w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            AluSltu: w_alu_result = {{(XLEN-1){1'b0}}, (w_a < w_b)};
            AluSll:  w_alu_result = w_a << w_b[ShW-1:0];
            AluSrl:  w_alu_result = w_a >> w_b[ShW-1:0];
            AluSra:  w_alu_result = XLEN'($signed(w_a) >>> w_b[ShW-1:0]);
            default: w_alu_result = {XLEN{1'b0}};
        endcase
    end

    // Output-register FSM: a new accept wins over a drain so back-to-back ops stay FULL.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StEmpty;
            r_owner     <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= {XLEN{1'b0}};
            r_rsp_zero  <= 1'b0;
        end else begin
            case (r_state)
                StEmpty, StFull: begin
                    if (w_accept) begin
                        r_state     <= StFull;
                        r_owner     <= w_gnt_idx;
                        r_rsp_valid <= req_onehot(w_gnt_idx);
                        r_rsp_data  <= w_alu_result;
                        r_rsp_zero  <= (w_alu_result == {XLEN{1'b0}});
                    end else if (w_drain) begin
                        r_state     <= StEmpty;
                        r_rsp_valid <= 2'b00;
                    end else begin
                        r_state     <= r_state;
                    end
                end
                default: begin
                    r_state     <= StEmpty;
                    r_rsp_valid <= 2'b00;
                end
            endcase
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_zero  = r_rsp_zero;

`ifdef ALU_ARB_STATS_EN
    logic [31:0] r_grant_cnt0;
    logic [31:0] r_grant_cnt1;
    logic [31:0] r_conflict_cnt;

    // Saturating grant and contention counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant_cnt0   <= 32'd0;
            r_grant_cnt1   <= 32'd0;
            r_conflict_cnt <= 32'd0;
        end else begin
            if (w_accept && !w_gnt_idx && (r_grant_cnt0 != 32'hFFFF_FFFF)) begin
                r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
            end
            if (w_accept && w_gnt_idx && (r_grant_cnt1 != 32'hFFFF_FFFF)) begin
                r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
            end
            if ((&i_req_valid) && w_can_accept && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

    assign o_grant_cnt0   = r_grant_cnt0;
    assign o_grant_cnt1   = r_grant_cnt1;
    assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule
